// File: rtl/wh_switch_arbiter_pkg.sv
// Shared router types: flit encodings, port indices and small helpers.
// Imported by the switch allocator, its interface and arbiter.
package noc_pkg;

  localparam int PORT_NUM = 5;

  typedef logic [2:0] port_idx_t;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    HEAD   = 2'b01,
    BODY   = 2'b10,
    TAIL   = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_state_e;

  localparam port_idx_t P_XP    = 3'd0;
  localparam port_idx_t P_XM    = 3'd1;
  localparam port_idx_t P_YM    = 3'd2;
  localparam port_idx_t P_YP    = 3'd3;
  localparam port_idx_t P_LOCAL = 3'd4;

  function automatic port_idx_t oh2idx(
    input logic [PORT_NUM-1:0] oh
  );
    port_idx_t r;
    unique case (1'b1)
      oh[0]:   r = 3'd0;
      oh[1]:   r = 3'd1;
      oh[2]:   r = 3'd2;
      oh[3]:   r = 3'd3;
      oh[4]:   r = 3'd4;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic port_idx_t next_ptr(
    input port_idx_t p
  );
    return (p == P_LOCAL) ? 3'd0 : p + 3'd1;
  endfunction

endpackage

// File: rtl/wh_switch_arbiter_if.sv
// Request/grant and crossbar-select bundle between the
// route-compute side and the switch allocator.
interface wh_switch_arbiter_if;
  import noc_pkg::*;

  logic [PORT_NUM-1:0]        req_valid;
  port_idx_t [PORT_NUM-1:0]   req_port;
  logic [PORT_NUM-1:0][1:0]   req_type;
  logic [PORT_NUM-1:0]        credit_in;
  logic [PORT_NUM-1:0]        gnt;
  logic [PORT_NUM-1:0]        xbar_vld;
  port_idx_t [PORT_NUM-1:0]   xbar_sel;
  logic [PORT_NUM-1:0]        out_locked;
  logic                       proto_err;

  modport master (
    output req_valid, req_port, req_type, credit_in,
    input  gnt, xbar_vld, xbar_sel, out_locked, proto_err
  );

  modport slave (
    input  req_valid, req_port, req_type, credit_in,
    output gnt, xbar_vld, xbar_sel, out_locked, proto_err
  );

endinterface

// File: rtl/wh_switch_arbiter_rr_arb5.sv
// Five-request round-robin arbiter: one-hot grant to the first
// requester found scanning upward from the pointer, wrapping at 5.
module rr_arb5
  import noc_pkg::*;
(
  input  logic [PORT_NUM-1:0] req_i,
  input  port_idx_t           ptr_i,
  output logic [PORT_NUM-1:0] gnt_o
);

  logic [3:0] s;

  // Scan from the pointer and keep only the first hit
  always_comb begin
    gnt_o = '0;
    s     = '0;
    for (int k = 0; k < PORT_NUM; k++) begin
      s = {1'b0, ptr_i} + 4'(k);
      if (s >= 4'd5) s = s - 4'd5;
      if (req_i[s[2:0]] && (gnt_o == '0))
        gnt_o[s[2:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/wh_switch_arbiter.sv
// Wormhole switch allocator: per-output lock, round-robin and
// credit tracking, with a registered crossbar select for ST.
module wh_switch_arbiter
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 5
) (
  input logic                clk,
  input logic                rst,
  wh_switch_arbiter_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);

  out_state_e               state_q [PORT_NUM];
  port_idx_t                owner_q [PORT_NUM];
  port_idx_t                ptr_q   [PORT_NUM];
  logic [CW-1:0]            cnt_q   [PORT_NUM];
  logic [CW-1:0]            cnt_d   [PORT_NUM];
  logic [PORT_NUM-1:0]      xvld_q;
  port_idx_t [PORT_NUM-1:0] xsel_q;
  logic                     err_q;

  logic [PORT_NUM-1:0] elig    [PORT_NUM];
  logic [PORT_NUM-1:0] arb_req [PORT_NUM];
  logic [PORT_NUM-1:0] ogn     [PORT_NUM];
  port_idx_t           gidx    [PORT_NUM];
  flit_type_e          gft     [PORT_NUM];
  logic [PORT_NUM-1:0] og_any;
  logic [PORT_NUM-1:0] gnt_raw;
  logic                proto_hit;
  logic                cred_err;
  flit_type_e          ft;

  // Classify each request against its output's lock state
  always_comb begin
    proto_hit = 1'b0;
    ft        = SINGLE;
    for (int o = 0; o < PORT_NUM; o++) begin
      elig[o] = '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (bus.req_valid[i] &&
            bus.req_port[i] == port_idx_t'(o)) begin
          ft = flit_type_e'(bus.req_type[i]);
          if (state_q[o] == ST_IDLE) begin
            if (ft == SINGLE || ft == HEAD)
              elig[o][i] = 1'b1;
            else
              proto_hit = 1'b1;
          end else if (owner_q[o] == port_idx_t'(i)) begin
            if (ft == BODY || ft == TAIL)
              elig[o][i] = 1'b1;
            else
              proto_hit = 1'b1;
          end else if (ft == BODY || ft == TAIL) begin
            proto_hit = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < PORT_NUM; i++) begin
      if (bus.req_valid[i] && bus.req_port[i] > P_LOCAL)
        proto_hit = 1'b1;
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
    assign arb_req[o] = (cnt_q[o] != '0) ? elig[o] : '0;

    rr_arb5 u_arb (
      .req_i (arb_req[o]),
      .ptr_i (ptr_q[o]),
      .gnt_o (ogn[o])
    );

    assign og_any[o] = |ogn[o];
    assign gidx[o]   = oh2idx(ogn[o]);
    assign gft[o]    = flit_type_e'(bus.req_type[gidx[o]]);
  end

  // Fold per-output grants back onto the inputs
  always_comb begin
    gnt_raw = '0;
    for (int o = 0; o < PORT_NUM; o++)
      gnt_raw = gnt_raw | ogn[o];
  end

  // Credit bookkeeping; overflow saturates and flags an error
  always_comb begin
    cred_err = 1'b0;
    for (int o = 0; o < PORT_NUM; o++) begin
      cnt_d[o] = cnt_q[o];
      case ({og_any[o], bus.credit_in[o]})
        2'b10: cnt_d[o] = cnt_q[o] - CW'(1);
        2'b01: begin
          if (cnt_q[o] == CNT_MAX)
            cred_err = 1'b1;
          else
            cnt_d[o] = cnt_q[o] + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Lock FSM, pointer, credits and ST-stage crossbar registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORT_NUM; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
        cnt_q[o]   <= CNT_MAX;
      end
      xvld_q <= '0;
      xsel_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= err_q | proto_hit | cred_err;
      xvld_q <= og_any;
      for (int o = 0; o < PORT_NUM; o++) begin
        cnt_q[o] <= cnt_d[o];
        if (og_any[o]) begin
          xsel_q[o] <= gidx[o];
          case (state_q[o])
            ST_IDLE: begin
              ptr_q[o] <= next_ptr(gidx[o]);
              if (gft[o] == HEAD) begin
                state_q[o] <= ST_LOCKED;
                owner_q[o] <= gidx[o];
              end
            end
            ST_LOCKED: begin
              if (gft[o] == TAIL)
                state_q[o] <= ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Lock status straight from the registered state
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++)
      bus.out_locked[o] = (state_q[o] == ST_LOCKED);
  end

  assign bus.gnt       = rst ? gnt_raw : '0;
  assign bus.xbar_vld  = xvld_q;
  assign bus.xbar_sel  = xsel_q;
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_wh_switch_arbiter.sv
// Scenario bench for the wormhole switch allocator; expected
// crossbar selects are queued at grant time and checked one cycle later.
module tb_wh_switch_arbiter;
  import noc_pkg::*;

  typedef struct {
    logic [4:0]      vld;
    logic [4:0][2:0] sel;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  wh_switch_arbiter_if bus();

  wh_switch_arbiter #(.FIFO_DEPTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clr_req();
    bus.req_valid = '0;
    bus.req_port  = '0;
    bus.req_type  = '0;
    bus.credit_in = '0;
  endtask

  task automatic set_req(input int i, input int p,
                         input flit_type_e t);
    bus.req_valid[i] = 1'b1;
    bus.req_port[i]  = 3'(p);
    bus.req_type[i]  = t;
  endtask

  // One SA cycle: check gnt, queue the ST result, check the
  // ST result of this grant after the edge.
  task automatic cycle(input string tag, input logic [4:0] eg);
    exp_t e;
    int   p;
    @(negedge clk);
    n_chk++;
    if (bus.gnt !== eg) begin
      n_fail++;
      $display("FAIL %s gnt: got %b want %b", tag, bus.gnt, eg);
    end
    e.vld = '0;
    e.sel = '0;
    for (int i = 0; i < 5; i++) begin
      if (eg[i]) begin
        p = int'(bus.req_port[i]);
        e.vld[p] = 1'b1;
        e.sel[p] = 3'(i);
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      if (bus.xbar_vld !== e.vld) begin
        n_fail++;
        $display("FAIL %s xbar_vld: got %b want %b",
                 tag, bus.xbar_vld, e.vld);
      end
      for (int o = 0; o < 5; o++) begin
        if (e.vld[o]) begin
          n_chk++;
          if (bus.xbar_sel[o] !== e.sel[o]) begin
            n_fail++;
            $display("FAIL %s xbar_sel[%0d]: got %0d want %0d",
                     tag, o, bus.xbar_sel[o], e.sel[o]);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    clr_req();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clr_req();
    rst = 1'b0;
    set_req(0, 1, SINGLE);
    #1;
    n_chk++;
    if (bus.gnt !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_gnt: got %b want 00000", bus.gnt);
    end
    repeat (2) @(posedge clk);
    #1;
    clr_req();
    rst = 1'b1;
    n_chk++;
    if (bus.xbar_vld !== 5'b0 || bus.out_locked !== 5'b0 ||
        bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out: got vld %b lock %b err %b want 0",
               bus.xbar_vld, bus.out_locked, bus.proto_err);
    end
    for (int o = 0; o < 5; o++) begin
      n_chk++;
      if (dut.cnt_q[o] !== 3'd5) begin
        n_fail++;
        $display("FAIL rst_cnt[%0d]: got %0d want 5",
                 o, dut.cnt_q[o]);
      end
    end
  endtask

  task automatic test_single();
    set_req(4, 0, SINGLE);
    cycle("single", 5'b10000);
    clr_req();
    n_chk++;
    if (dut.cnt_q[0] !== 3'd4 || bus.out_locked[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_state: got cnt %0d lock %b want 4 0",
               dut.cnt_q[0], bus.out_locked[0]);
    end
    bus.credit_in[0] = 1'b1;
    cycle("single_refill", 5'b00000);
    clr_req();
  endtask

  task automatic test_rr();
    logic [4:0] order [6];
    order[0] = 5'b00001; order[1] = 5'b00100;
    order[2] = 5'b01000; order[3] = 5'b00001;
    order[4] = 5'b00100; order[5] = 5'b01000;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 4, SINGLE);
      set_req(2, 4, SINGLE);
      set_req(3, 4, SINGLE);
      bus.credit_in[4] = 1'b1;
      cycle($sformatf("rr%0d", k), order[k]);
    end
    clr_req();
    n_chk++;
    if (dut.cnt_q[4] !== 3'd5 || bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_end: got cnt %0d err %b want 5 0",
               dut.cnt_q[4], bus.proto_err);
    end
  endtask

  task automatic test_lock();
    flit_type_e pkt [4];
    pkt[0] = HEAD; pkt[1] = BODY; pkt[2] = BODY; pkt[3] = TAIL;
    for (int k = 0; k < 4; k++) begin
      clr_req();
      set_req(1, 3, pkt[k]);
      set_req(4, 3, HEAD);
      bus.credit_in[3] = 1'b1;
      cycle($sformatf("lock_pkt%0d", k), 5'b00010);
      n_chk++;
      if (bus.out_locked[3] !== (k < 3)) begin
        n_fail++;
        $display("FAIL lock_flag%0d: got %b want %b",
                 k, bus.out_locked[3], k < 3);
      end
    end
    clr_req();
    set_req(4, 3, HEAD);
    bus.credit_in[3] = 1'b1;
    cycle("lock_waiter", 5'b10000);
    clr_req();
    set_req(4, 3, TAIL);
    bus.credit_in[3] = 1'b1;
    cycle("lock_waiter_tail", 5'b10000);
    clr_req();
    n_chk++;
    if (bus.out_locked[3] !== 1'b0 || bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_end: got lock %b err %b want 0 0",
               bus.out_locked[3], bus.proto_err);
    end
  endtask

  task automatic test_credit();
    for (int k = 0; k < 6; k++) begin
      set_req(0, 2, SINGLE);
      cycle($sformatf("cred%0d", k), (k < 5) ? 5'b00001 : 5'b0);
    end
    n_chk++;
    if (dut.cnt_q[2] !== 3'd0) begin
      n_fail++;
      $display("FAIL cred_empty: got %0d want 0", dut.cnt_q[2]);
    end
    bus.credit_in[2] = 1'b1;
    cycle("cred_same_cycle", 5'b00000);
    cycle("cred_grant_and_return", 5'b00001);
    n_chk++;
    if (dut.cnt_q[2] !== 3'd1) begin
      n_fail++;
      $display("FAIL cred_hold: got %0d want 1", dut.cnt_q[2]);
    end
    bus.credit_in[2] = 1'b0;
    cycle("cred_last", 5'b00001);
    clr_req();
    bus.credit_in[2] = 1'b1;
    for (int k = 0; k < 5; k++)
      cycle($sformatf("cred_refill%0d", k), 5'b00000);
    clr_req();
    n_chk++;
    if (dut.cnt_q[2] !== 3'd5 || bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL cred_end: got cnt %0d err %b want 5 0",
               dut.cnt_q[2], bus.proto_err);
    end
  endtask

  task automatic test_proto();
    set_req(3, 1, BODY);
    cycle("proto_body", 5'b00000);
    clr_req();
    n_chk++;
    if (bus.proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_body: got %b want 1", bus.proto_err);
    end
    cycle("proto_idle", 5'b00000);
    n_chk++;
    if (bus.proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_sticky: got %b want 1", bus.proto_err);
    end
    do_reset();
    n_chk++;
    if (bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_clear: got %b want 0", bus.proto_err);
    end
    bus.credit_in[0] = 1'b1;
    cycle("proto_credit", 5'b00000);
    clr_req();
    n_chk++;
    if (dut.cnt_q[0] !== 3'd5 || bus.proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_credit: got cnt %0d err %b want 5 1",
               dut.cnt_q[0], bus.proto_err);
    end
    do_reset();
    set_req(2, 7, SINGLE);
    cycle("proto_port", 5'b00000);
    clr_req();
    n_chk++;
    if (bus.proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_port: got %b want 1", bus.proto_err);
    end
    do_reset();
  endtask

  task automatic test_midreset();
    set_req(2, 0, HEAD);
    cycle("mid_head", 5'b00100);
    set_req(2, 0, BODY);
    cycle("mid_body0", 5'b00100);
    cycle("mid_body1", 5'b00100);
    n_chk++;
    if (dut.cnt_q[0] !== 3'd2 || bus.out_locked[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got cnt %0d lock %b want 2 1",
               dut.cnt_q[0], bus.out_locked[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if (bus.gnt !== 5'b0 || bus.out_locked !== 5'b0 ||
        bus.xbar_vld !== 5'b0 || dut.cnt_q[0] !== 3'd5) begin
      n_fail++;
      $display("FAIL mid_rst: got gnt %b lock %b vld %b cnt %0d",
               bus.gnt, bus.out_locked, bus.xbar_vld, dut.cnt_q[0]);
    end
    clr_req();
    @(posedge clk);
    #1;
    rst = 1'b1;
    set_req(3, 0, HEAD);
    cycle("mid_new_head", 5'b01000);
    n_chk++;
    if (bus.out_locked[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_relock: got %b want 1", bus.out_locked[0]);
    end
    set_req(3, 0, TAIL);
    cycle("mid_new_tail", 5'b01000);
    clr_req();
    n_chk++;
    if (bus.out_locked[0] !== 1'b0 || bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_end: got lock %b err %b want 0 0",
               bus.out_locked[0], bus.proto_err);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_rr();
    test_lock();
    test_credit();
    test_proto();
    test_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
